// File: rtl/axis_bram_line_packer.sv
// AXI-Stream <-> wide-BRAM line engine: INGEST packs stream words into BRAM lines,
// EMIT reads BRAM lines back out as stream words, both with full backpressure.
module axis_bram_line_packer #(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned WORDS_PER_LINE = 36,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned RD_LATENCY     = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 mode,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                start_addr,
  input  logic [ADDR_WIDTH-1:0]                bound_addr,
  output logic                                 busy,
  output logic                                 done,
  input  logic [WORD_WIDTH-1:0]                s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,
  output logic [WORD_WIDTH-1:0]                m_axis_tdata,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic                                 bram_en,
  output logic                                 bram_we,
  output logic [ADDR_WIDTH-1:0]                bram_addr,
  output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] bram_wdata,
  input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] bram_rdata
);

  localparam int unsigned      CNT_W      = $clog2(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WORDS_PER_LINE - 2);
  localparam logic [1:0]       WAIT_LAST  = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_COMMIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t                                   r_state;
  logic [CNT_W-1:0]                         r_cnt;
  logic [1:0]                               r_wait;
  logic [ADDR_WIDTH-1:0]                    r_addr;
  logic [ADDR_WIDTH-1:0]                    r_bound;
  logic                                     r_tlast_seen;
  logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] r_line;
  logic                                     r_busy;
  logic                                     r_done;
  logic                                     r_s_tready;
  logic                                     r_m_tvalid;
  logic                                     r_m_tlast;
  logic                                     r_bram_en;
  logic                                     r_bram_we;

  logic w_s_beat;
  logic w_m_beat;
  logic w_at_bound;
  logic w_cnt_last;

  assign w_s_beat   = s_axis_tvalid & r_s_tready;
  assign w_m_beat   = r_m_tvalid & m_axis_tready;
  assign w_at_bound = (r_addr == r_bound);
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Control outputs are registered alongside each state transition so they
  // always line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_wait       <= '0;
      r_addr       <= '0;
      r_bound      <= '0;
      r_tlast_seen <= 1'b0;
      r_line       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_s_tready   <= 1'b0;
      r_m_tvalid   <= 1'b0;
      r_m_tlast    <= 1'b0;
      r_bram_en    <= 1'b0;
      r_bram_we    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr       <= start_addr;
            r_bound      <= bound_addr;
            r_cnt        <= '0;
            r_line       <= '0;
            r_tlast_seen <= 1'b0;
            r_busy       <= 1'b1;
            if (mode) begin
              r_bram_en <= 1'b1;
              r_state   <= S_RD_ISSUE;
            end else begin
              r_s_tready <= 1'b1;
              r_state    <= S_FILL;
            end
          end
        end

        S_FILL: begin
          if (w_s_beat) begin
            r_line[r_cnt] <= s_axis_tdata;
            r_cnt         <= r_cnt + CNT_W'(1);
            if (s_axis_tlast || w_cnt_last) begin
              r_tlast_seen <= s_axis_tlast;
              r_s_tready   <= 1'b0;
              r_bram_en    <= 1'b1;
              r_bram_we    <= 1'b1;
              r_state      <= S_COMMIT;
            end
          end
        end

        S_COMMIT: begin
          r_bram_en <= 1'b0;
          r_bram_we <= 1'b0;
          if (r_tlast_seen || w_at_bound) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            // Cleared line gives zero fill if the next line ends early on tlast.
            r_addr     <= r_addr + ADDR_WIDTH'(1);
            r_cnt      <= '0;
            r_line     <= '0;
            r_s_tready <= 1'b1;
            r_state    <= S_FILL;
          end
        end

        S_RD_ISSUE: begin
          r_bram_en <= 1'b0;
          r_wait    <= '0;
          r_state   <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          if (r_wait == WAIT_LAST) begin
            r_line     <= bram_rdata;
            r_cnt      <= '0;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= 1'b0;
            r_state    <= S_DRAIN;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end

        S_DRAIN: begin
          if (w_m_beat) begin
            if (w_cnt_last) begin
              r_m_tvalid <= 1'b0;
              r_m_tlast  <= 1'b0;
              if (w_at_bound) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_FINISH;
              end else begin
                r_addr    <= r_addr + ADDR_WIDTH'(1);
                r_cnt     <= '0;
                r_bram_en <= 1'b1;
                r_state   <= S_RD_ISSUE;
              end
            end else begin
              r_cnt     <= r_cnt + CNT_W'(1);
              r_m_tlast <= (r_cnt == CNT_PENULT) && w_at_bound;
            end
          end
        end

        S_FINISH: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign s_axis_tready = r_s_tready;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tdata  = r_m_tvalid ? r_line[r_cnt] : '0;
  assign bram_en       = r_bram_en;
  assign bram_we       = r_bram_we;
  assign bram_addr     = r_addr;
  assign bram_wdata    = r_line;

endmodule

// File: tb/tb_axis_bram_line_packer.sv
// Directed bench for axis_bram_line_packer: ingest, zero-fill, wrap, emit with
// backpressure, mid-job reset and dropped start, against a 2-cycle BRAM model.
module tb_axis_bram_line_packer;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 36;
  localparam int unsigned AW = 12;
  localparam int unsigned RL = 2;
  localparam int unsigned LW = W * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] bound_addr = '0;
  logic          busy, done;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [LW-1:0] bram_wdata;
  logic [LW-1:0] bram_rdata;

  always #5 clk = ~clk;

  axis_bram_line_packer #(
    .WORD_WIDTH    (W),
    .WORDS_PER_LINE(N),
    .ADDR_WIDTH    (AW),
    .RD_LATENCY    (RL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .start        (start),
    .start_addr   (start_addr),
    .bound_addr   (bound_addr),
    .busy         (busy),
    .done         (done),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .bram_en      (bram_en),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_wdata   (bram_wdata),
    .bram_rdata   (bram_rdata)
  );

  // BRAM model with two-cycle read latency
  logic [LW-1:0] mem [0:(1<<AW)-1];
  logic [LW-1:0] rd_p1 = '0;
  logic [LW-1:0] rd_p2 = '0;
  always @(posedge clk) begin
    if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
    if (bram_en && !bram_we) rd_p1 <= mem[bram_addr];
    rd_p2 <= rd_p1;
  end
  assign bram_rdata = rd_p2;

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  int unsigned   done_cnt = 0;
  int unsigned   rd_cnt = 0;
  logic [AW-1:0] wlog_addr[$];
  logic [LW-1:0] wlog_data[$];

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bram_en && !bram_we) rd_cnt++;
    if (bram_en && bram_we) begin
      wlog_addr.push_back(bram_addr);
      wlog_data.push_back(bram_wdata);
    end
  end

  task automatic check(input string tag, input logic [LW-1:0] obsv, input logic [LW-1:0] expv);
    n_cmp++;
    assert (obsv === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obsv, expv);
    end
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [W-1:0] base, input int unsigned nvalid);
    logic [N-1:0][W-1:0] l;
    l = '0;
    for (int unsigned k = 0; k < N; k++)
      if (k < nvalid) l[k] = base + W'(k);
    return l;
  endfunction

  task automatic settle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_start(input logic m, input logic [AW-1:0] sa, input logic [AW-1:0] ba,
                          input string tag);
    @(negedge clk);
    mode = m; start_addr = sa; bound_addr = ba; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = ~m; start_addr = 12'h5A5; bound_addr = 12'h3C3;
    check({tag, "_busy_after_start"}, busy, 1'b1);
  endtask

  task automatic ingest(input logic [W-1:0] base, input int unsigned n,
                        input int unsigned tlast_idx, input string tag);
    int unsigned idx = 0;
    int unsigned cyc = 0;
    while (idx < n && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (bram_we) check({tag, "_commit_tready"}, s_axis_tready, 1'b0);
      if (cyc % 7 == 3) begin
        s_axis_tvalid = 1'b0;
      end else begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = base + W'(idx);
        s_axis_tlast  = (idx == tlast_idx);
      end
      if (s_axis_tvalid && s_axis_tready) idx++;
    end
    check({tag, "_beats"}, idx, n);
  endtask

  task automatic emit(input logic [W-1:0] base, input int unsigned n,
                      input int unsigned stop_at, input string tag);
    int unsigned idx = 0;
    int unsigned cyc = 0;
    logic        stall = 1'b0;
    logic [W-1:0] pd = '0;
    logic        pl = 1'b0;
    while (idx < stop_at && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        check({tag, "_hold_valid"}, m_axis_tvalid, 1'b1);
        check({tag, "_hold_data"}, m_axis_tdata, pd);
        check({tag, "_hold_last"}, m_axis_tlast, pl);
      end
      m_axis_tready = ($urandom_range(0, 3) != 0);
      if (m_axis_tvalid && m_axis_tready) begin
        check({tag, "_data"}, m_axis_tdata, base + W'(idx));
        check({tag, "_last"}, m_axis_tlast, (idx == n - 1));
        idx++;
      end
      stall = m_axis_tvalid && !m_axis_tready;
      pd    = m_axis_tdata;
      pl    = m_axis_tlast;
    end
    check({tag, "_words"}, idx, stop_at);
  endtask

  task automatic wait_done(input string tag);
    int unsigned i = 0;
    logic        seen = 1'b0;
    while (!seen && i < 200) begin
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (bram_we) check({tag, "_commit_tready"}, s_axis_tready, 1'b0);
      if (done) seen = 1'b1;
      i++;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    m_axis_tready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_s_tready"}, s_axis_tready, 1'b0);
    check({tag, "_m_tvalid"}, m_axis_tvalid, 1'b0);
    check({tag, "_m_tlast"}, m_axis_tlast, 1'b0);
    check({tag, "_m_tdata"}, m_axis_tdata, '0);
    check({tag, "_bram_en"}, bram_en, 1'b0);
    check({tag, "_bram_we"}, bram_we, 1'b0);
    check({tag, "_bram_addr"}, bram_addr, '0);
    check({tag, "_bram_wdata"}, bram_wdata, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0, r0, w0;

    // Reset state, during and after reset
    @(negedge clk);
    check_all_zero("rst_held");
    settle(2);
    rst = 1'b0;
    settle(1);
    check_all_zero("rst_rel");

    // Two full lines, with valid gaps
    d0 = done_cnt; w0 = wlog_addr.size();
    do_start(1'b0, 12'h010, 12'h011, "two_line");
    ingest(16'h0000, 72, 72, "two_line");
    wait_done("two_line");
    settle(3);
    check("two_line_writes", wlog_addr.size() - w0, 2);
    check("two_line_addr0", wlog_addr[w0], 12'h010);
    check("two_line_data0", wlog_data[w0], mk_line(16'h0000, 36));
    check("two_line_addr1", wlog_addr[w0+1], 12'h011);
    check("two_line_data1", wlog_data[w0+1], mk_line(16'h0024, 36));
    check("two_line_done", done_cnt - d0, 1);

    // Early tlast on word 9 gives a zero-filled single line
    d0 = done_cnt; w0 = wlog_addr.size();
    do_start(1'b0, 12'h020, 12'h025, "early_last");
    ingest(16'h5A00, 10, 9, "early_last");
    wait_done("early_last");
    settle(3);
    check("early_last_writes", wlog_addr.size() - w0, 1);
    check("early_last_addr", wlog_addr[w0], 12'h020);
    check("early_last_data", wlog_data[w0], mk_line(16'h5A00, 10));
    check("early_last_done", done_cnt - d0, 1);

    // tlast on the final word of a full line: single commit only
    d0 = done_cnt; w0 = wlog_addr.size();
    do_start(1'b0, 12'h030, 12'h035, "full_last");
    ingest(16'h7700, 36, 35, "full_last");
    wait_done("full_last");
    settle(3);
    check("full_last_writes", wlog_addr.size() - w0, 1);
    check("full_last_addr", wlog_addr[w0], 12'h030);
    check("full_last_data", wlog_data[w0], mk_line(16'h7700, 36));

    // Address wrap 0xFFF -> 0x000 -> 0x001
    d0 = done_cnt; w0 = wlog_addr.size();
    do_start(1'b0, 12'hFFF, 12'h001, "wrap");
    ingest(16'h1000, 108, 108, "wrap");
    wait_done("wrap");
    settle(3);
    check("wrap_writes", wlog_addr.size() - w0, 3);
    check("wrap_addr0", wlog_addr[w0], 12'hFFF);
    check("wrap_addr1", wlog_addr[w0+1], 12'h000);
    check("wrap_addr2", wlog_addr[w0+2], 12'h001);
    check("wrap_data1", wlog_data[w0+1], mk_line(16'h1024, 36));
    check("wrap_done", done_cnt - d0, 1);

    // Emit the wrapped lines back with random backpressure
    d0 = done_cnt; r0 = rd_cnt; w0 = wlog_addr.size();
    do_start(1'b1, 12'hFFF, 12'h001, "emit");
    emit(16'h1000, 108, 108, "emit");
    wait_done("emit");
    settle(3);
    check("emit_no_valid_after", m_axis_tvalid, 1'b0);
    check("emit_reads", rd_cnt - r0, 3);
    check("emit_no_writes", wlog_addr.size() - w0, 0);
    check("emit_done", done_cnt - d0, 1);

    // Reset in the middle of DRAIN
    d0 = done_cnt; w0 = wlog_addr.size();
    do_start(1'b1, 12'hFFF, 12'h001, "abort");
    emit(16'h1000, 108, 6, "abort");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("abort_rst");
    @(negedge clk);
    rst = 1'b0;
    m_axis_tready = 1'b0;
    settle(3);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_writes", wlog_addr.size() - w0, 0);
    check("abort_idle", busy, 1'b0);

    // Fresh single-line job; a start pulse while busy must be dropped
    d0 = done_cnt; r0 = rd_cnt; w0 = wlog_addr.size();
    do_start(1'b0, 12'h050, 12'h050, "single");
    @(negedge clk);
    mode = 1'b1; start_addr = 12'h070; bound_addr = 12'h070; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("single_busy_kept", busy, 1'b1);
    ingest(16'h3300, 36, 36, "single");
    wait_done("single");
    settle(6);
    check("single_writes", wlog_addr.size() - w0, 1);
    check("single_addr", wlog_addr[w0], 12'h050);
    check("single_data", wlog_data[w0], mk_line(16'h3300, 36));
    check("single_no_reads", rd_cnt - r0, 0);
    check("single_done", done_cnt - d0, 1);
    check("single_idle_after", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
